// File: rtl/fft_frame_sched.sv
// fft_frame_sched: buffers the free-running sample stream into the prefetch
// FIFO and, once a full frame is buffered, streams exactly one frame to the
// FFT core over valid/ready with a last-beat marker.
// Optional feature macro: FFT_SCHED_STATS_EN enables the dropped-sample counter.
module fft_frame_sched #(
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned DEPTH_WIDTH = 11
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [DEPTH_WIDTH:0]   cfg_frame_len,
   input  logic                   s_valid,
   input  logic [DATA_WIDTH-1:0]  s_data,
   output logic                   fifo_wr_en,
   output logic [DATA_WIDTH-1:0]  fifo_wr_data,
   input  logic                   fifo_wr_vld,
   output logic                   fifo_rd_en,
   input  logic                   fifo_rd_vld,
   input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
   output logic                   fft_tvalid,
   output logic                   fft_tlast,
   output logic [DATA_WIDTH-1:0]  fft_tdata,
   input  logic                   fft_tready,
   output logic                   busy,
   output logic                   frame_done,
   output logic [15:0]            ovf_cnt
);

   localparam int unsigned OCC_WIDTH = DEPTH_WIDTH + 1;
   localparam logic [OCC_WIDTH-1:0] CAP     = OCC_WIDTH'(2 ** DEPTH_WIDTH);
   localparam logic [OCC_WIDTH-1:0] MIN_LEN = OCC_WIDTH'(8);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_STREAM,
      S_FLUSH
   } state_t;

   state_t                 state_q, state_d;
   logic [OCC_WIDTH-1:0]   occ_q;
   logic [OCC_WIDTH-1:0]   len_q, len_d;
   logic [OCC_WIDTH-1:0]   beat_q, beat_d;
   logic                   done_q, done_d;
   logic                   can_wr;

   // Limit a requested frame length to the legal 8..capacity range
   function automatic logic [OCC_WIDTH-1:0] clamp_len(input logic [OCC_WIDTH-1:0] v);
      if (v < MIN_LEN)  return MIN_LEN;
      else if (v > CAP) return CAP;
      else              return v;
   endfunction

   assign can_wr       = s_valid & fifo_wr_vld & (occ_q < CAP);
   assign fifo_wr_data = s_data;
   assign fft_tdata    = fifo_rd_data;
   assign busy         = (state_q != S_IDLE);
   assign frame_done   = done_q;

   // Next-state and handshake decode; writes/pops are same-cycle combinational
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      beat_d     = beat_q;
      done_d     = 1'b0;
      fifo_wr_en = 1'b0;
      fifo_rd_en = 1'b0;
      fft_tvalid = 1'b0;
      fft_tlast  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (en) begin
               len_d   = clamp_len(cfg_frame_len);
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            fifo_wr_en = can_wr;
            if (!en) begin
               state_d = S_FLUSH;
            end else if (occ_q >= len_q) begin
               state_d = S_STREAM;
               beat_d  = '0;
            end
         end
         S_STREAM: begin
            fifo_wr_en = can_wr;
            fft_tvalid = fifo_rd_vld;
            fifo_rd_en = fifo_rd_vld & fft_tready;
            fft_tlast  = fifo_rd_vld & (beat_q == (len_q - OCC_WIDTH'(1)));
            if (fifo_rd_en) begin
               beat_d = beat_q + OCC_WIDTH'(1);
               if (fft_tlast) begin
                  done_d  = 1'b1;
                  len_d   = clamp_len(cfg_frame_len);
                  state_d = en ? S_FILL : S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            fifo_rd_en = fifo_rd_vld;
            if ((occ_q == '0) && !fifo_rd_vld) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         beat_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         done_q  <= done_d;
      end
   end

   // FIFO occupancy mirror: +1 per write, -1 per pop
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         case ({fifo_wr_en, fifo_rd_en})
            2'b10:   occ_q <= occ_q + OCC_WIDTH'(1);
            2'b01:   occ_q <= occ_q - OCC_WIDTH'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

`ifdef FFT_SCHED_STATS_EN
   logic        drop;
   logic [15:0] ovf_q;

   assign drop    = ((state_q == S_FILL) || (state_q == S_STREAM)) & s_valid & ~fifo_wr_en;
   assign ovf_cnt = ovf_q;

   // Saturating count of samples refused while acquiring
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= '0;
      end else if (drop && (ovf_q != 16'hFFFF)) begin
         ovf_q <= ovf_q + 16'd1;
      end
   end
`else
   assign ovf_cnt = '0;
`endif

endmodule
